sample_accumulator: RTL and testbench

Windowed accumulator for the ring-oscillator temperature sensor path. Sits directly downstream of the gated edge counter and upstream of the FSM controller / UART byte mux. On a start request it accumulates 2^LOG2_SAMPLES counter samples, then presents the 24-bit sum and the truncated mean with a one-cycle done pulse. Results are held until the next window completes.

---
 rtl/sensor_pkg.sv | 15 +
 rtl/sample_minmax.sv | 49 ++++
 rtl/sample_accumulator.sv | 176 +++++++++++++++++
 tb/tb_sample_accumulator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the ring-oscillator temperature sensor path:
// accumulator state encoding and the default datapath widths.
package sensor_pkg;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_ACCUM = 2'd1,
        ACC_HOLD  = 2'd2
    } acc_state_e;

    localparam int unsigned SENSOR_COUNT_W      = 16;
    localparam int unsigned SENSOR_SUM_W        = 24;
    localparam int unsigned SENSOR_LOG2_SAMPLES = 4;

endpackage

// File: rtl/sample_minmax.sv
// Per-window minimum/maximum tracker for accepted counter samples.
// min_o/max_o present the running extremes including the sample accepted
// in the current cycle, so the parent can register the final window
// extremes on the same edge that accepts the last sample.
module sample_minmax
    import sensor_pkg::*;
#(
    parameter int unsigned COUNT_W = SENSOR_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [COUNT_W-1:0] sample_i,
    output logic [COUNT_W-1:0] min_o,
    output logic [COUNT_W-1:0] max_o
);

    logic [COUNT_W-1:0] min_q, min_d;
    logic [COUNT_W-1:0] max_q, max_d;

    // Next extremes: clear restarts the window, an accepted sample may extend it.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = '1;
            max_d = '0;
        end else if (valid_i) begin
            if (sample_i < min_q) min_d = sample_i;
            if (sample_i > max_q) max_d = sample_i;
        end
    end

    // Running extremes register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_d;
    assign max_o = max_d;

endmodule

// File: rtl/sample_accumulator.sv
// Windowed accumulator for the ring-oscillator temperature sensor.
// A start request (with en high) opens a window of 2^LOG2_SAMPLES accepted
// samples; at window end the saturating sum, truncated mean and saturation
// flag are published with a one-cycle done pulse and held until the next
// window completes. Optional per-window min/max outputs are built when the
// macro ACC_MINMAX_EN is defined.
module sample_accumulator
    import sensor_pkg::*;
#(
    parameter int unsigned COUNT_W      = SENSOR_COUNT_W,
    parameter int unsigned SUM_W        = SENSOR_SUM_W,
    parameter int unsigned LOG2_SAMPLES = SENSOR_LOG2_SAMPLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic               sample_valid,
    input  logic [COUNT_W-1:0] sample,
    output logic [SUM_W-1:0]   sum,
    output logic [COUNT_W-1:0] avg,
    output logic               done,
    output logic               busy,
    output logic               sat
`ifdef ACC_MINMAX_EN
    ,
    output logic [COUNT_W-1:0] min_s,
    output logic [COUNT_W-1:0] max_s
`endif
);

    localparam int unsigned AW = SUM_W + 1;
    localparam logic [LOG2_SAMPLES-1:0] IDX_LAST = '1;

    acc_state_e              state_q, state_d;
    logic [SUM_W-1:0]        acc_q, acc_d;
    logic [LOG2_SAMPLES-1:0] idx_q, idx_d;
    logic                    satf_q, satf_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [COUNT_W-1:0]      avg_q, avg_d;
    logic                    sat_q, sat_d;
    logic                    done_q, done_d;
    logic                    clear;
    logic                    accept;
    logic [SUM_W:0]          add_res;

    // Adds a zero-extended sample; on overflow the result sticks at all-ones
    // and the returned MSB flags the overflow.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0]   a,
                                               input logic [COUNT_W-1:0] b);
        logic [AW-1:0] full;
        full = {1'b0, a} + AW'(b);
        if (full[SUM_W]) begin
            return {1'b1, {SUM_W{1'b1}}};
        end
        return full;
    endfunction

    // Truncated mean; works whether the shifted sum is wider or narrower than a sample.
    function automatic logic [COUNT_W-1:0] mean_of(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] sh;
        sh = s >> LOG2_SAMPLES;
        return COUNT_W'(sh);
    endfunction

    assign add_res = sat_add(acc_q, sample);

    // Window control, accumulation and result publication.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        satf_d  = satf_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ACC_IDLE, ACC_HOLD: begin
                if (en && start) begin
                    state_d = ACC_ACCUM;
                    clear   = 1'b1;
                end
            end
            ACC_ACCUM: begin
                if (!en) begin
                    state_d = ACC_IDLE;
                end else if (start) begin
                    // Restart; a coincident strobe belongs to no window.
                    clear = 1'b1;
                end else if (sample_valid) begin
                    accept = 1'b1;
                    acc_d  = add_res[SUM_W-1:0];
                    satf_d = satf_q | add_res[SUM_W];
                    idx_d  = idx_q + LOG2_SAMPLES'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ACC_HOLD;
                        sum_d   = acc_d;
                        avg_d   = mean_of(acc_d);
                        sat_d   = satf_d;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ACC_IDLE;
        endcase
        if (clear) begin
            acc_d  = '0;
            idx_d  = '0;
            satf_d = 1'b0;
        end
    end

    // State, accumulator and published-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            satf_q  <= 1'b0;
            sum_q   <= '0;
            avg_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            satf_q  <= satf_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign avg  = avg_q;
    assign sat  = sat_q;
    assign done = done_q;
    assign busy = (state_q == ACC_ACCUM);

`ifdef ACC_MINMAX_EN
    logic [COUNT_W-1:0] run_min, run_max;
    logic [COUNT_W-1:0] min_s_q, max_s_q;

    sample_minmax #(
        .COUNT_W (COUNT_W)
    ) u_minmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .valid_i  (accept),
        .sample_i (sample),
        .min_o    (run_min),
        .max_o    (run_max)
    );

    // Window extremes are published together with the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_s_q <= '1;
            max_s_q <= '0;
        end else if (done_d) begin
            min_s_q <= run_min;
            max_s_q <= run_max;
        end
    end

    assign min_s = min_s_q;
    assign max_s = max_s_q;
`endif

endmodule

// File: tb/tb_sample_accumulator.sv
// Bench for sample_accumulator: a default-width instance and a SUM_W=18
// instance share one directed stimulus; a window-level model (list of
// accepted samples, results computed at window end) is compared every cycle.
module tb_sample_accumulator;

    localparam int M_IDLE = 0;
    localparam int M_ACC  = 1;
    localparam int M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;

    logic [23:0] sum;
    logic [15:0] avg;
    logic        done, busy, sat;
    logic [17:0] sum18;
    logic [15:0] avg18;
    logic        done18, busy18, sat18;
`ifdef ACC_MINMAX_EN
    logic [15:0] min_s, max_s, min18, max18;
`endif

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    // Model state, index 0 = 24-bit sum build, index 1 = 18-bit sum build.
    int     mode_m [2] = '{M_IDLE, M_IDLE};
    int     cnt_m  [2] = '{0, 0};
    int     win_m  [2][16];
    longint sum_m  [2] = '{0, 0};
    longint avg_m  [2] = '{0, 0};
    bit     sat_m  [2] = '{0, 0};
    bit     done_m [2] = '{0, 0};
    longint min_m  [2] = '{16'hFFFF, 16'hFFFF};
    longint max_m  [2] = '{0, 0};

    sample_accumulator dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .sample_valid(sample_valid), .sample(sample),
        .sum(sum), .avg(avg), .done(done), .busy(busy), .sat(sat)
`ifdef ACC_MINMAX_EN
        , .min_s(min_s), .max_s(max_s)
`endif
    );

    sample_accumulator #(.SUM_W(18)) dut18 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .sample_valid(sample_valid), .sample(sample),
        .sum(sum18), .avg(avg18), .done(done18), .busy(busy18), .sat(sat18)
`ifdef ACC_MINMAX_EN
        , .min_s(min18), .max_s(max18)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic close_window(input int k);
        longint tot, lim, mn, mx;
        tot = 0; mn = 16'hFFFF; mx = 0;
        for (int i = 0; i < 16; i++) begin
            tot += win_m[k][i];
            if (win_m[k][i] < mn) mn = win_m[k][i];
            if (win_m[k][i] > mx) mx = win_m[k][i];
        end
        lim = (k == 0) ? ((64'd1 << 24) - 1) : ((64'd1 << 18) - 1);
        sum_m[k]  = (tot > lim) ? lim : tot;
        sat_m[k]  = (tot > lim);
        avg_m[k]  = (sum_m[k] / 16) & 16'hFFFF;
        min_m[k]  = mn;
        max_m[k]  = mx;
        done_m[k] = 1'b1;
        mode_m[k] = M_HOLD;
    endtask

    task automatic model_step(input int k);
        done_m[k] = 1'b0;
        if (mode_m[k] == M_ACC) begin
            if (!en) mode_m[k] = M_IDLE;
            else if (start) cnt_m[k] = 0;
            else if (sample_valid) begin
                win_m[k][cnt_m[k]] = int'(sample);
                cnt_m[k]++;
                if (cnt_m[k] == 16) close_window(k);
            end
        end else if (en && start) begin
            mode_m[k] = M_ACC;
            cnt_m[k]  = 0;
        end
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mode_m[k] = M_IDLE; cnt_m[k] = 0; sum_m[k] = 0; avg_m[k] = 0;
                sat_m[k] = 0; done_m[k] = 0; min_m[k] = 16'hFFFF; max_m[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("sum",    longint'(sum),    sum_m[0]);
        chk("avg",    longint'(avg),    avg_m[0]);
        chk("sat",    longint'(sat),    longint'(sat_m[0]));
        chk("done",   longint'(done),   longint'(done_m[0]));
        chk("busy",   longint'(busy),   longint'(mode_m[0] == M_ACC));
        chk("sum18",  longint'(sum18),  sum_m[1]);
        chk("avg18",  longint'(avg18),  avg_m[1]);
        chk("sat18",  longint'(sat18),  longint'(sat_m[1]));
        chk("done18", longint'(done18), longint'(done_m[1]));
        chk("busy18", longint'(busy18), longint'(mode_m[1] == M_ACC));
`ifdef ACC_MINMAX_EN
        chk("min_s", longint'(min_s), min_m[0]);
        chk("max_s", longint'(max_s), max_m[0]);
        chk("min18", longint'(min18), min_m[1]);
        chk("max18", longint'(max18), max_m[1]);
`endif
        if (done) ndone++;
    end

    task automatic send(input int v);
        sample_valid = 1'b1;
        sample = 16'(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int dc, nd0;

        // Reset state.
        idle(3);
        chk("rst_sum", longint'(sum), 0);
        chk("rst_avg", longint'(avg), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sat", longint'(sat), 0);
        rst_n = 1'b1;
        en = 1'b1;
        idle(2);

        // Sixteen samples of 1000.
        pulse_start();
        for (int i = 0; i < 16; i++) send(1000);
        chk("t1_done", longint'(done), 1);
        chk("t1_busy", longint'(busy), 0);
        chk("t1_sum", longint'(sum), 24'h003E80);
        chk("t1_avg", longint'(avg), 1000);
        chk("t1_sat", longint'(sat), 0);
        idle(1);
        chk("t1_done_pulse", longint'(done), 0);

        // Ramp 0..15 back-to-back; measure start-to-done latency.
        start = 1'b1;
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done && dc < 0) dc = c;
            sample_valid = (c <= 16);
            sample = 16'(c - 1);
        end
        sample_valid = 1'b0;
        chk("t2_latency", dc, 17);
        chk("t2_sum", longint'(sum), 120);
        chk("t2_avg", longint'(avg), 7);
`ifdef ACC_MINMAX_EN
        chk("t2_min", longint'(min_s), 0);
        chk("t2_max", longint'(max_s), 15);
`endif

        // Restart after 8 samples.
        @(negedge clk);
        nd0 = ndone;
        pulse_start();
        for (int i = 0; i < 8; i++) send(500);
        pulse_start();
        for (int i = 0; i < 16; i++) send(200);
        idle(2); #1;
        chk("t3_ndone", ndone - nd0, 1);
        chk("t3_sum", longint'(sum), 3200);
        chk("t3_avg", longint'(avg), 200);

        // en dropped mid-window keeps the previous results.
        pulse_start();
        for (int i = 0; i < 16; i++) send(1000);
        @(negedge clk);
        nd0 = ndone;
        pulse_start();
        for (int i = 0; i < 10; i++) send(700);
        en = 1'b0;
        for (int i = 0; i < 8; i++) send(700);
        #1;
        chk("t4_ndone", ndone - nd0, 0);
        chk("t4_busy", longint'(busy), 0);
        chk("t4_sum", longint'(sum), 16000);
        chk("t4_avg", longint'(avg), 1000);
        // start while en low is ignored.
        pulse_start();
        idle(1);
        chk("t4_start_ignored", longint'(busy), 0);
        en = 1'b1;
        @(negedge clk);

        // Saturation in the 18-bit build, then recovery.
        pulse_start();
        for (int i = 0; i < 16; i++) send(16'hFFFF);
        chk("t5_sum18", longint'(sum18), 18'h3FFFF);
        chk("t5_sat18", longint'(sat18), 1);
        chk("t5_avg18", longint'(avg18), 16'h3FFF);
        chk("t5_sum24", longint'(sum), 24'h0FFFF0);
        chk("t5_sat24", longint'(sat), 0);
        pulse_start();
        for (int i = 0; i < 16; i++) send(1);
        chk("t5b_sat18", longint'(sat18), 0);
        chk("t5b_sum18", longint'(sum18), 16);

        // start coincident with a strobe mid-window discards that sample.
        pulse_start();
        send(5);
        send(6);
        start = 1'b1;
        send(9999);
        start = 1'b0;
        for (int i = 0; i < 15; i++) send(1);
        chk("t6_early_done", longint'(done), 0);
        send(1);
        chk("t6_done", longint'(done), 1);
        chk("t6_sum", longint'(sum), 16);

        // Asynchronous reset mid-window.
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 5; i++) send(300);
        nd0 = ndone;
        #2 rst_n = 1'b0;
        #1;
        chk("t7_sum", longint'(sum), 0);
        chk("t7_busy", longint'(busy), 0);
        chk("t7_avg", longint'(avg), 0);
        chk("t7_sat", longint'(sat), 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) send(300);
        idle(2); #1;
        chk("t7_ndone", ndone - nd0, 0);
        chk("t7_sum_after", longint'(sum), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
